// File: rtl/sd_dat0_block_rx.sv
// sd_dat0_block_rx: receives one SD DAT0 block (start bit, payload, CRC16, end bit),
// deserialises payload bytes and checks the CRC16-CCITT computed over the payload.
module sd_dat0_block_rx #(
    parameter int BLOCK_BYTES  = 512,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       SD_CLK_RISE,
    input  logic       SD_DAT0,
    output logic [7:0] BYTE_OUT,
    output logic       BYTE_VALID,
    output logic       BLOCK_DONE,
    output logic       CRC_OK,
    output logic       CRC_ERR,
    output logic       FRAME_ERR,
    output logic       TIMEOUT_ERR,
    output logic       BUSY
);
    localparam int BW = $clog2(BLOCK_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END_BIT, DONE} state_t;

    state_t        state, next;
    logic [6:0]    shift;
    logic [2:0]    bit_cnt;
    logic [3:0]    crc_cnt;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] to_cnt;
    logic [15:0]   crc, rx_crc;
    logic [7:0]    shift_nxt;
    logic [15:0]   crc_nxt;

    assign shift_nxt  = {shift, SD_DAT0};
    assign crc_nxt    = {crc[14:0], 1'b0} ^ ((SD_DAT0 ^ crc[15]) ? 16'h1021 : 16'h0000);
    assign BLOCK_DONE = state == DONE;
    assign BUSY       = state != IDLE;

    always_ff @(posedge CLK) begin
        state <= RESET ? IDLE : next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:       if (START) next = WAIT_START;
            WAIT_START: if (SD_CLK_RISE) next = !SD_DAT0 ? DATA : (to_cnt == TO_LAST) ? DONE : WAIT_START;
            DATA:       if (SD_CLK_RISE && bit_cnt == 3'd7 && byte_cnt == BYTE_LAST) next = CRC;
            CRC:        if (SD_CLK_RISE && crc_cnt == 4'hf) next = END_BIT;
            END_BIT:    if (SD_CLK_RISE) next = DONE;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift       <= '0;
            bit_cnt     <= '0;
            crc_cnt     <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            crc         <= '0;
            rx_crc      <= '0;
            BYTE_OUT    <= '0;
            BYTE_VALID  <= 1'b0;
            CRC_OK      <= 1'b0;
            CRC_ERR     <= 1'b0;
            FRAME_ERR   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            BYTE_VALID <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    bit_cnt     <= '0;
                    crc_cnt     <= '0;
                    byte_cnt    <= '0;
                    to_cnt      <= '0;
                    crc         <= '0;
                    rx_crc      <= '0;
                    CRC_OK      <= 1'b0;
                    CRC_ERR     <= 1'b0;
                    FRAME_ERR   <= 1'b0;
                    TIMEOUT_ERR <= 1'b0;
                end
                WAIT_START: if (SD_CLK_RISE && SD_DAT0) begin
                    to_cnt <= (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
                    if (to_cnt == TO_LAST) TIMEOUT_ERR <= 1'b1;
                end
                DATA: if (SD_CLK_RISE) begin
                    shift   <= shift_nxt[6:0];
                    crc     <= crc_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        BYTE_OUT   <= shift_nxt;
                        BYTE_VALID <= 1'b1;
                        byte_cnt   <= byte_cnt + 1'b1;
                    end
                end
                CRC: if (SD_CLK_RISE) begin
                    rx_crc  <= {rx_crc[14:0], SD_DAT0};
                    crc_cnt <= crc_cnt + 4'd1;
                end
                END_BIT: if (SD_CLK_RISE) begin
                    CRC_ERR   <= rx_crc != crc;
                    FRAME_ERR <= ~SD_DAT0;
                    CRC_OK    <= (rx_crc == crc) && SD_DAT0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dat0_block_rx.sv
// tb_sd_dat0_block_rx: directed bench for sd_dat0_block_rx, a 512-byte and a 4-byte
// instance sharing clock, reset, strobe and DAT0.
module tb_sd_dat0_block_rx;
    logic clk = 1'b0, rst = 1'b1, stb = 1'b0, dat = 1'b1;
    logic b_start = 1'b0, s_start = 1'b0;
    logic [7:0] b_byte, s_byte;
    logic b_bv, b_done, b_ok, b_cerr, b_ferr, b_terr, b_busy;
    logic s_bv, s_done, s_ok, s_cerr, s_ferr, s_terr, s_busy;
    int checks = 0, errors = 0;
    int b_nbytes = 0, b_nbad = 0, b_ndone = 0, s_nbytes = 0, s_ndone = 0;
    logic [7:0] tx[$];

    always #5 clk = ~clk;

    sd_dat0_block_rx #(.BLOCK_BYTES(512), .TIMEOUT_CLKS(10)) u_big (
        .CLK(clk), .RESET(rst), .START(b_start), .SD_CLK_RISE(stb), .SD_DAT0(dat),
        .BYTE_OUT(b_byte), .BYTE_VALID(b_bv), .BLOCK_DONE(b_done), .CRC_OK(b_ok),
        .CRC_ERR(b_cerr), .FRAME_ERR(b_ferr), .TIMEOUT_ERR(b_terr), .BUSY(b_busy)
    );

    sd_dat0_block_rx #(.BLOCK_BYTES(4), .TIMEOUT_CLKS(10)) u_small (
        .CLK(clk), .RESET(rst), .START(s_start), .SD_CLK_RISE(stb), .SD_DAT0(dat),
        .BYTE_OUT(s_byte), .BYTE_VALID(s_bv), .BLOCK_DONE(s_done), .CRC_OK(s_ok),
        .CRC_ERR(s_cerr), .FRAME_ERR(s_ferr), .TIMEOUT_ERR(s_terr), .BUSY(s_busy)
    );

    always @(negedge clk) begin
        if (b_bv) begin
            b_nbytes++;
            if (b_byte != 8'hff) b_nbad++;
        end
        if (b_done) b_ndone++;
        if (s_bv) s_nbytes++;
        if (s_done) s_ndone++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] st(input bit sm);
        return sm ? {s_ok, s_cerr, s_ferr, s_terr} : {b_ok, b_cerr, b_ferr, b_terr};
    endfunction

    function automatic logic [15:0] crc_model();
        logic [15:0] c = 16'h0;
        foreach (tx[i]) for (int k = 7; k >= 0; k--)
            c = {c[14:0], 1'b0} ^ ((tx[i][k] ^ c[15]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic strobe_bit(input logic b, input int period);
        repeat (period - 1) begin @(posedge clk); #1; end
        dat = b;
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic pulse_start(input bit sm);
        if (sm) s_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic clear_counts();
        b_nbytes = 0; b_nbad = 0; b_ndone = 0; s_nbytes = 0; s_ndone = 0;
    endtask

    task automatic send_block(input bit sm, input logic [15:0] crc, input logic endb,
                              input int period, input int lead, input bit mid_start);
        clear_counts();
        pulse_start(sm);
        repeat (lead) strobe_bit(1'b1, period);
        strobe_bit(1'b0, period);
        foreach (tx[i]) for (int k = 7; k >= 0; k--) begin
            if (mid_start && i == 2 && k == 7) pulse_start(sm);
            strobe_bit(tx[i][k], period);
            if (sm && k == 0) begin
                check("byte_valid", s_bv, 1);
                check("byte_out", s_byte, tx[i]);
            end
        end
        for (int k = 15; k >= 0; k--) strobe_bit(crc[k], period);
        strobe_bit(endb, period);
        check("done_pulse", sm ? s_done : b_done, 1);
        @(posedge clk); #1;
        check("done_one_clk", sm ? s_done : b_done, 0);
        check("busy_after", sm ? s_busy : b_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_big", {b_byte, b_bv, b_done, b_ok, b_cerr, b_ferr, b_terr, b_busy}, 0);
        check("reset_small", {s_byte, s_bv, s_done, s_ok, s_cerr, s_ferr, s_terr, s_busy}, 0);

        tx.delete();
        repeat (512) tx.push_back(8'hff);
        send_block(0, 16'h7fa1, 1'b1, 4, 2, 0);
        check("ff_nbytes", b_nbytes, 512);
        check("ff_nbad", b_nbad, 0);
        check("ff_ndone", b_ndone, 1);
        check("ff_status", st(0), 4'b1000);

        send_block(0, 16'h7fa0, 1'b1, 4, 0, 0);
        check("badcrc_nbytes", b_nbytes, 512);
        check("badcrc_status", st(0), 4'b0100);

        tx.delete();
        tx.push_back(8'h00); tx.push_back(8'h01); tx.push_back(8'h80); tx.push_back(8'ha5);
        send_block(1, crc_model(), 1'b1, 1, 0, 1);
        check("small_nbytes", s_nbytes, 4);
        check("small_ndone", s_ndone, 1);
        check("small_status", st(1), 4'b1000);

        send_block(1, crc_model(), 1'b0, 1, 1, 0);
        check("frame_status", st(1), 4'b0010);
        check("frame_ndone", s_ndone, 1);

        clear_counts();
        pulse_start(0);
        repeat (9) strobe_bit(1'b1, 2);
        check("to_before", {b_terr, b_busy, b_done}, 3'b010);
        strobe_bit(1'b1, 2);
        check("to_flag", {b_terr, b_done}, 2'b11);
        check("to_status", st(0), 4'b0001);
        repeat (3) begin @(posedge clk); #1; end
        check("to_held", {b_terr, b_busy, b_ndone[1:0]}, 4'b1001);

        tx.delete();
        repeat (512) tx.push_back(8'hff);
        send_block(0, 16'h7fa1, 1'b1, 1, 9, 0);
        check("after_to_nbytes", b_nbytes, 512);
        check("after_to_status", st(0), 4'b1000);

        pulse_start(0);
        strobe_bit(1'b0, 1);
        repeat (100 * 8 + 3) strobe_bit(1'b1, 1);
        check("mid_busy", b_busy, 1);
        rst = 1'b1; stb = 1'b1; dat = 1'b1; b_start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0; b_start = 1'b0;
        check("mid_reset", {b_byte, b_bv, b_done, b_ok, b_cerr, b_ferr, b_terr, b_busy}, 0);
        strobe_bit(1'b0, 1);
        check("idle_after_reset", {b_busy, b_bv}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_dat0_block_rx.md
Name: sd_dat0_block_rx

Overview:
- Receives one SD-card data block on the 1-bit DAT0 line: start bit, payload bytes, a 16-bit CRC, then an end bit.
- Sits between the SD pin/clock-generator logic (upstream) and the sector buffer writer (downstream).
- Deserialises payload bits into bytes.
- Runs the CRC16-CCITT (x^16+x^12+x^5+1, init 0) LFSR bit-serially over the payload and checks it against the received CRC.
- Reports block status to the SD command sequencer.

Parameters:
- BLOCK_BYTES, 512, payload bytes per block (1..4096).
- TIMEOUT_CLKS, 65535, SD clock edges allowed between START and the start bit before TIMEOUT_ERR.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; arms the receiver for one block.
- SD_CLK_RISE  in  1  one-CLK strobe marking an SD clock rising edge; DAT0 is sampled only on cycles where this is high.
- SD_DAT0  in  1  DAT0 pin, already synchronised to CLK.
- BYTE_OUT  out  8  received payload byte, MSB first on the wire.
- BYTE_VALID  out  1  one-CLK pulse; BYTE_OUT is valid.
- BLOCK_DONE  out  1  one-CLK pulse at block end, whether the result is good, bad or timed out.
- CRC_OK  out  1  level; computed CRC equals received CRC and the end bit is 1.
- CRC_ERR  out  1  level; CRC mismatch.
- FRAME_ERR  out  1  level; end bit sampled as 0.
- TIMEOUT_ERR  out  1  level; no start bit within TIMEOUT_CLKS edges.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: the synchronous RESET forces the IDLE state and clears all outputs, the CRC register, the bit/byte counters and the timeout counter to 0.
  - RESET has priority over every other input in the same cycle, including mid-block.
- States: IDLE, WAIT_START, DATA, CRC, END_BIT, DONE.
- Sampling: state advances and bits are sampled only on CLK cycles with SD_CLK_RISE=1, except IDLE->WAIT_START and DONE->IDLE, which need no strobe.
- IDLE:
  - START=1 -> WAIT_START.
  - On entry to WAIT_START, CRC_OK, CRC_ERR, FRAME_ERR and TIMEOUT_ERR clear, and the CRC register and counters clear.
  - START in any other state is ignored.
- WAIT_START: on each strobe:
  - SD_DAT0=0 -> DATA. The start bit is not fed to the CRC.
  - Otherwise the timeout counter increments. When the counter reaches TIMEOUT_CLKS, set TIMEOUT_ERR and go to DONE.
  - Exactly TIMEOUT_CLKS high samples trigger the timeout; a 0 on that same strobe still wins and goes to DATA.
- DATA: on each strobe:
  - Shift SD_DAT0 into the shift register (LSB in, so the first wire bit ends up as bit 7).
  - Advance the CRC with inv = SD_DAT0 ^ crc[15]; crc <= {crc[14:0],0} ^ (inv ? 16'h1021 : 0).
  - After the 8th bit of a byte, BYTE_OUT <= the full byte and BYTE_VALID=1 for the next CLK cycle only. There is no backpressure; the downstream must accept every byte.
  - After byte BLOCK_BYTES-1 completes -> CRC.
- CRC: 16 strobes shift SD_DAT0 MSB-first into a received-CRC register. The computed CRC is frozen during this state. After the 16th bit -> END_BIT.
- END_BIT: on one strobe:
  - CRC_ERR = (rx_crc != crc).
  - FRAME_ERR = ~SD_DAT0.
  - CRC_OK = ~CRC_ERR & ~FRAME_ERR.
  - -> DONE.
- DONE: BLOCK_DONE=1 for exactly one CLK, then -> IDLE. Status levels are held until the next accepted START or RESET.
- Widths:
  - Bit counter: 3 bits.
  - Byte counter: clog2(BLOCK_BYTES+1) bits.
  - Timeout counter: clog2(TIMEOUT_CLKS+1) bits, saturating.
- Latency: BYTE_VALID appears 1 CLK after the strobe that samples the last bit of the byte. BLOCK_DONE appears 1 CLK after the end-bit strobe.
- SD_CLK_RISE on consecutive CLK cycles must be handled: a full rate of one bit per CLK has no bubbles.

Test Plan:
- 512 bytes of 0xFF with CRC 0x7FA1 and end bit 1 (strobe every 4th CLK) -> 512 BYTE_VALID pulses all 0xFF; BLOCK_DONE once; CRC_OK=1, CRC_ERR=0, FRAME_ERR=0.
- Same block with the received CRC 0x7FA0 -> all 512 bytes delivered, CRC_ERR=1, CRC_OK=0.
- BLOCK_BYTES=4, payload 0x00 0x01 0x80 0xA5, continuous strobes -> bytes out in order with correct values; CRC compared against the bench model; back-to-back strobes lose no bits.
- TIMEOUT_CLKS=10, DAT0 held 1 after START -> TIMEOUT_ERR=1 and BLOCK_DONE on the 10th strobe. Then a second START clears TIMEOUT_ERR and a normal block receives correctly.
- Good data and CRC with the end bit 0 -> FRAME_ERR=1, CRC_ERR=0, CRC_OK=0.
- RESET asserted mid-DATA (byte 100) -> next CLK is IDLE with all outputs 0. START pulsed during an active block is ignored with no counter disturbance.
